uart_tx_ctrl: RTL and testbench

UART transmit controller that owns and sequences a 16x-oversample baud tick counter and frames parallel bytes onto the serial line. It accepts one byte per valid/ready handshake and shifts out start, data (LSB first), optional parity and 1 or 2 stop bits. It sits between the host-side byte source and the TXD pin, alongside the receive path.

---
 rtl/uart_tx_ctrl_if.sv | 26 ++
 rtl/uart_tx_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake, frame configuration and serial-line observation for the UART transmitter.
interface uart_tx_ctrl_if #(
    parameter int DIV_W  = 10,
    parameter int DATA_W = 8
);
    logic [DIV_W-1:0]  divisor;
    logic              parity_en;
    logic              parity_odd;
    logic              two_stop;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              txd;
    logic              busy;
    logic              tick;

    modport master (
        output divisor, parity_en, parity_odd, two_stop, tx_data, tx_valid,
        input  tx_ready, txd, busy, tick
    );

    modport slave (
        input  divisor, parity_en, parity_odd, two_stop, tx_data, tx_valid,
        output tx_ready, txd, busy, tick
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: 16x-oversample baud timing plus start/data/parity/stop framing.
// Configuration is captured at accept so the frame in flight is immune to input changes.
module uart_tx_ctrl #(
    parameter int DIV_W  = 10,
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave tx_if
);
    localparam int OVS_W = $clog2(OVS);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [OVS_W-1:0]  ovs_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] sh_q;
    logic              par_en_q;
    logic              par_bit_q;
    logic              two_stop_q;
    logic              stop2_q;
    logic              txd_q;
    logic              ready_q;
    logic              busy_q;

    logic              baud_tick;
    logic              bit_end;

    assign baud_tick = (state_q != IDLE) && (cnt_q == div_q);
    assign bit_end   = baud_tick && (ovs_q == OVS_LAST);

    assign tx_if.txd      = txd_q;
    assign tx_if.tx_ready = ready_q;
    assign tx_if.busy     = busy_q;
    assign tx_if.tick     = baud_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            ovs_q      <= '0;
            idx_q      <= '0;
            sh_q       <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            // Baud and oversample counters only run while a frame is on the line.
            if (state_q == IDLE || baud_tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == IDLE) begin
                ovs_q <= '0;
            end else if (baud_tick) begin
                ovs_q <= (ovs_q == OVS_LAST) ? '0 : ovs_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (tx_if.tx_valid && ready_q) begin
                        state_q    <= START;
                        div_q      <= tx_if.divisor;
                        sh_q       <= tx_if.tx_data;
                        par_en_q   <= tx_if.parity_en;
                        par_bit_q  <= (^tx_if.tx_data) ^ tx_if.parity_odd;
                        two_stop_q <= tx_if.two_stop;
                        stop2_q    <= 1'b0;
                        idx_q      <= '0;
                        txd_q      <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        txd_q   <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
                            state_q <= par_en_q ? PARITY : STOP;
                            txd_q   <= par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            txd_q <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end
                end
                STOP: begin
                    // Second stop bit reuses this state; stop2_q marks that the first has elapsed.
                    if (bit_end) begin
                        if (two_stop_q && !stop2_q) begin
                            stop2_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level reference model compared every cycle, directed literal cases, random traffic.
module tb_uart_tx_ctrl;
    localparam int DIV_W  = 10;
    localparam int DATA_W = 8;
    localparam int OVS    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DIV_W(DIV_W), .DATA_W(DATA_W)) bus ();

    uart_tx_ctrl #(.DIV_W(DIV_W), .DATA_W(DATA_W), .OVS(OVS)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is a list of bit values, each held bit_len clocks after accept.
    bit m_active;
    int m_t, m_total, m_bl, m_dp1, m_n;
    int m_bits[12];
    int acc_cnt;

    initial begin
        m_active = 1'b0;
        acc_cnt  = 0;
        m_t = 0; m_total = 0; m_bl = 1; m_dp1 = 1; m_n = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_t++;
                if (m_t == m_total) m_active = 1'b0;
            end else if (bus.tx_valid === 1'b1) begin
                m_n = 0;
                m_bits[m_n] = 0; m_n++;
                for (int i = 0; i < DATA_W; i++) begin
                    m_bits[m_n] = int'(bus.tx_data[i]); m_n++;
                end
                if (bus.parity_en) begin
                    m_bits[m_n] = int'((^bus.tx_data) ^ bus.parity_odd); m_n++;
                end
                m_bits[m_n] = 1; m_n++;
                if (bus.two_stop) begin
                    m_bits[m_n] = 1; m_n++;
                end
                m_dp1    = int'(bus.divisor) + 1;
                m_bl     = OVS * m_dp1;
                m_total  = m_n * m_bl;
                m_t      = 0;
                m_active = 1'b1;
                acc_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && rst === 1'b0) begin
                if (m_active) begin
                    check("txd",      bus.txd,      m_bits[m_t / m_bl]);
                    check("tx_ready", bus.tx_ready, 0);
                    check("busy",     bus.busy,     1);
                    check("tick",     bus.tick,     ((m_t % m_dp1) == m_dp1 - 1) ? 1 : 0);
                end else begin
                    check("txd",      bus.txd,      1);
                    check("tx_ready", bus.tx_ready, 1);
                    check("busy",     bus.busy,     0);
                    check("tick",     bus.tick,     0);
                end
            end
        end
    end

    task automatic run_frame(input string name, input logic [7:0] data, input int div,
                             input bit pe, input bit po, input bit ts,
                             input int nbits, input logic [11:0] exp_bits, input int exp_lat);
        int  bl, c, ticks;
        bit  done;
        bl = OVS * (div + 1);
        @(negedge clk); #2;
        bus.tx_data    = data;
        bus.divisor    = DIV_W'(div);
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.two_stop   = ts;
        bus.tx_valid   = 1'b1;
        @(posedge clk); #2;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = ~data;
        bus.parity_en  = ~pe;
        bus.parity_odd = ~po;
        bus.two_stop   = ~ts;
        c = 0; ticks = 0; done = 1'b0;
        while (!done && c < 5000) begin
            @(negedge clk);
            if ((c % bl) == bl / 2 && (c / bl) < nbits)
                check($sformatf("%s bit%0d", name, c / bl), bus.txd, exp_bits[c / bl]);
            if (bus.tick === 1'b1) ticks++;
            if (bus.tx_ready === 1'b1) done = 1'b1;
            else c++;
        end
        check($sformatf("%s latency", name), c, exp_lat);
        check($sformatf("%s ticks", name), ticks, nbits * OVS);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d expected completion", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, c1, c2, fall, w, a0;
        rst = 1'b1;
        bus.tx_valid = 1'b0; bus.tx_data = '0; bus.divisor = '0;
        bus.parity_en = 1'b0; bus.parity_odd = 1'b0; bus.two_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("reset txd",      bus.txd,      1);
        check("reset tx_ready", bus.tx_ready, 1);
        check("reset busy",     bus.busy,     0);
        check("reset tick",     bus.tick,     0);
        #2 rst = 1'b0;
        cmp_en = 1'b1;

        run_frame("A5",      8'hA5, 3, 1'b0, 1'b0, 1'b0, 10, 12'h34A, 640);
        run_frame("07 even", 8'h07, 3, 1'b1, 1'b0, 1'b0, 11, 12'h60E, 704);
        run_frame("07 odd",  8'h07, 3, 1'b1, 1'b1, 1'b0, 11, 12'h40E, 704);
        run_frame("00 2stp", 8'h00, 0, 1'b0, 1'b0, 1'b1, 11, 12'h600, 176);

        // Back-to-back 0x55 then 0xAA, divisor changed during the second frame.
        @(negedge clk); #2;
        bus.tx_data = 8'h55; bus.divisor = DIV_W'(1);
        bus.parity_en = 1'b0; bus.parity_odd = 1'b0; bus.two_stop = 1'b0;
        bus.tx_valid = 1'b1;
        @(posedge clk); #2;
        bus.tx_data = 8'hAA;
        c = 0; c1 = -1; c2 = -1; fall = -1;
        while (c2 < 0 && c < 2000) begin
            @(negedge clk);
            if (c1 < 0 && bus.tx_ready === 1'b1) c1 = c;
            if (c1 >= 0 && c > c1 && fall < 0 && bus.txd === 1'b0) fall = c;
            if (c1 >= 0 && c == c1 + 1) bus.tx_valid = 1'b0;
            if (c1 >= 0 && c == c1 + 10) bus.divisor = DIV_W'(7);
            if (c1 >= 0 && c > c1 + 1 && bus.tx_ready === 1'b1) c2 = c;
            c++;
        end
        check("b2b first ready",  c1,   320);
        check("b2b second start", fall, 321);
        check("b2b second ready", c2,   641);

        // Reset in the middle of data bit 3 of 0xFF.
        @(negedge clk); #2;
        bus.tx_data = 8'hFF; bus.divisor = DIV_W'(3);
        bus.parity_en = 1'b0; bus.two_stop = 1'b0; bus.tx_valid = 1'b1;
        @(posedge clk); #2;
        bus.tx_valid = 1'b0;
        repeat (4 * 64 + 11) @(negedge clk);
        check("pre-reset busy", bus.busy, 1);
        #1 rst = 1'b1;
        #1;
        check("async reset txd",      bus.txd,      1);
        check("async reset tx_ready", bus.tx_ready, 1);
        check("async reset busy",     bus.busy,     0);
        check("async reset tick",     bus.tick,     0);
        @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        run_frame("81 post-rst", 8'h81, 3, 1'b0, 1'b0, 1'b0, 10, 12'h302, 640);

        // Random traffic: random config, gaps, back-to-back runs and mid-frame input churn.
        for (int f = 0; f < 24; f++) begin
            @(negedge clk); #2;
            bus.tx_data    = DATA_W'($urandom);
            bus.divisor    = DIV_W'($urandom_range(0, 3));
            bus.parity_en  = 1'($urandom);
            bus.parity_odd = 1'($urandom);
            bus.two_stop   = 1'($urandom);
            bus.tx_valid   = 1'b1;
            a0 = acc_cnt; w = 0;
            while (acc_cnt == a0 && w < 3000) begin
                @(negedge clk); #2;
                w++;
            end
            check("random accept", (acc_cnt != a0) ? 1 : 0, 1);
            if ($urandom_range(0, 1) == 0) begin
                bus.tx_valid = 1'b0;
                w = 0;
                while (m_active && w < 3000) begin
                    @(negedge clk); #2;
                    bus.tx_data    = DATA_W'($urandom);
                    bus.divisor    = DIV_W'($urandom_range(0, 3));
                    bus.parity_en  = 1'($urandom);
                    bus.parity_odd = 1'($urandom);
                    bus.two_stop   = 1'($urandom);
                    w++;
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        bus.tx_valid = 1'b0;
        w = 0;
        while (m_active && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("final idle", m_active ? 1 : 0, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
